// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory bus between the instruction-fetch port
// and the data port of a MIPS core. It counts completed transactions per port
// and keeps a sticky flag for requester protocol violations.
`timescale 1ns/1ps
module mips_mem_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_read,
  input  logic [31:0]      i_address,
  output logic [31:0]      i_readdata,
  output logic             i_waitrequest,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_address,
  input  logic [31:0]      d_writedata,
  input  logic [3:0]       d_byteenable,
  output logic [31:0]      d_readdata,
  output logic             d_waitrequest,
  output logic [31:0]      m_address,
  output logic             m_read,
  output logic             m_write,
  output logic [31:0]      m_writedata,
  output logic [3:0]       m_byteenable,
  input  logic [31:0]      m_readdata,
  input  logic             m_waitrequest,
  output logic [CNT_W-1:0] i_count,
  output logic [CNT_W-1:0] d_count,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  localparam logic             LG_INSTR = 1'b0;
  localparam logic             LG_DATA  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] i_count_q, i_count_d;
  logic [CNT_W-1:0] d_count_q, d_count_d;
  logic             proto_err_q, proto_err_d;

  logic i_req_s, d_req_s;
  logic i_done_s, d_done_s;
  logic i_drop_s, d_drop_s;

  // Request, completion and withdrawal decode for both ports.
  always_comb begin
    i_req_s  = i_read;
    d_req_s  = d_read | d_write;
    i_done_s = (state_q == GRANT_I) & i_req_s & ~m_waitrequest;
    d_done_s = (state_q == GRANT_D) & d_req_s & ~m_waitrequest;
    i_drop_s = (state_q == GRANT_I) & ~i_req_s;
    d_drop_s = (state_q == GRANT_D) & ~d_req_s;
  end

  // State and last-grant registers; reset lands in IDLE with data marked last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= LG_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: arbitrate from IDLE, hand over directly on completion when the
  // other port waits, fall back to IDLE on completion or withdrawal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          if (ROUND_ROBIN != 0) begin
            state_d = (last_grant_q == LG_DATA) ? GRANT_I : GRANT_D;
          end else begin
            state_d = GRANT_D;
          end
        end else if (i_req_s) begin
          state_d = GRANT_I;
        end else if (d_req_s) begin
          state_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I: begin
        if (!i_req_s) begin
          state_d = IDLE;
        end else if (!m_waitrequest) begin
          state_d = d_req_s ? GRANT_D : IDLE;
        end else begin
          state_d = GRANT_I;
        end
      end
      GRANT_D: begin
        if (!d_req_s) begin
          state_d = IDLE;
        end else if (!m_waitrequest) begin
          state_d = i_req_s ? GRANT_I : IDLE;
        end else begin
          state_d = GRANT_D;
        end
      end
      default: state_d = IDLE;
    endcase

    // Remember which port was most recently granted, on every grant entry.
    if ((state_d == GRANT_I) && (state_q != GRANT_I)) begin
      last_grant_d = LG_INSTR;
    end else if ((state_d == GRANT_D) && (state_q != GRANT_D)) begin
      last_grant_d = LG_DATA;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Output decode: memory command mux and per-port stalls, all combinational.
  always_comb begin
    m_address    = 32'h0000_0000;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = 32'h0000_0000;
    m_byteenable = 4'b0000;
    case (state_q)
      GRANT_I: begin
        m_address    = i_address;
        m_read       = i_read;
        m_write      = 1'b0;
        m_writedata  = 32'h0000_0000;
        m_byteenable = 4'b1111;
      end
      GRANT_D: begin
        m_address    = d_address;
        m_read       = d_read & ~d_write;
        m_write      = d_write;
        m_writedata  = d_writedata;
        m_byteenable = d_byteenable;
      end
      default: begin
        m_read  = 1'b0;
        m_write = 1'b0;
      end
    endcase
    i_waitrequest = i_req_s & ~((state_q == GRANT_I) & ~m_waitrequest);
    d_waitrequest = d_req_s & ~((state_q == GRANT_D) & ~m_waitrequest);
    i_readdata    = m_readdata;
    d_readdata    = m_readdata;
  end

  // Next values for the completion counters and the sticky error flag.
  always_comb begin
    i_count_d   = i_done_s ? (i_count_q + CNT_ONE) : i_count_q;
    d_count_d   = d_done_s ? (d_count_q + CNT_ONE) : d_count_q;
    proto_err_d = proto_err_q | i_drop_s | d_drop_s | (d_read & d_write);
  end

  // Counter and error-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_count_q   <= {CNT_W{1'b0}};
      d_count_q   <= {CNT_W{1'b0}};
      proto_err_q <= 1'b0;
    end else begin
      i_count_q   <= i_count_d;
      d_count_q   <= d_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign i_count   = i_count_q;
  assign d_count   = d_count_q;
  assign proto_err = proto_err_q;

endmodule
